// File: rtl/spi_word_capture.sv
// SPI capture front-end: synchronises the raw SPI lines into sys_clk, frames on SS and
// deserialises MOSI/MISO in parallel into word pairs offered through a valid/ack handshake.
module spi_word_capture #(
    parameter int DATA_SIZE   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 sclk_in,
    input  logic                 ss_in,
    input  logic                 mosi_in,
    input  logic                 miso_in,
    output logic [DATA_SIZE-1:0] mosi_data,
    output logic [DATA_SIZE-1:0] miso_data,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 frame_active,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 frame_abort,
    output logic                 overrun
);

    localparam int unsigned NSYNC = SYNC_STAGES;
    localparam int unsigned CNT_W = $clog2(DATA_SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_SIZE - 1);

    localparam int unsigned L_SCLK = 0;
    localparam int unsigned L_SS   = 1;
    localparam int unsigned L_MOSI = 2;
    localparam int unsigned L_MISO = 3;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_t;

    logic [3:0]             r_sync [NSYNC];
    logic                   r_prev_sclk;
    logic                   r_prev_ss;
    logic [NSYNC-1:0]       r_fill;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_SIZE-1:0]   r_mosi_sh;
    logic [DATA_SIZE-1:0]   r_miso_sh;
    logic                   r_word_done;
    logic [DATA_SIZE-1:0]   r_mosi_data;
    logic [DATA_SIZE-1:0]   r_miso_data;
    logic                   r_valid;
    logic                   r_active;
    logic                   r_start;
    logic                   r_end;
    logic                   r_abort;
    logic                   r_overrun;

    logic [3:0]             w_sync;
    logic                   w_primed;
    logic                   w_sclk_rise;
    logic                   w_ss_rise;
    logic                   w_ss_fall;

    assign w_sync      = r_sync[NSYNC-1];
    assign w_primed    = r_fill[NSYNC-1];
    assign w_sclk_rise = w_sync[L_SCLK] & ~r_prev_sclk;
    assign w_ss_rise   = w_sync[L_SS] & ~r_prev_ss;
    assign w_ss_fall   = ~w_sync[L_SS] & r_prev_ss;

    // r_fill marks when the chain output holds a real post-reset sample, so the zeros
    // flushed out of a freshly reset chain are never mistaken for SS being low.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NSYNC; i++) r_sync[i] <= '0;
            r_prev_sclk <= 1'b0;
            r_prev_ss   <= 1'b0;
            r_fill      <= '0;
        end else begin
            r_sync[0] <= {miso_in, mosi_in, ss_in, sclk_in};
            for (int unsigned i = 1; i < NSYNC; i++) r_sync[i] <= r_sync[i-1];
            r_prev_sclk <= w_sync[L_SCLK];
            r_prev_ss   <= w_sync[L_SS];
            r_fill      <= {r_fill[NSYNC-2:0], 1'b1};
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= WAIT_IDLE;
            r_bit_cnt   <= '0;
            r_mosi_sh   <= '0;
            r_miso_sh   <= '0;
            r_word_done <= 1'b0;
            r_mosi_data <= '0;
            r_miso_data <= '0;
            r_valid     <= 1'b0;
            r_active    <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_abort     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_abort     <= 1'b0;
            r_word_done <= 1'b0;

            case (r_state)
                WAIT_IDLE: begin
                    if (w_primed && !w_sync[L_SS]) r_state <= IDLE;
                end
                IDLE: begin
                    if (w_ss_rise) begin
                        r_start   <= 1'b1;
                        r_active  <= 1'b1;
                        r_bit_cnt <= '0;
                        r_overrun <= 1'b0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // SS edges win over a coincident SCLK edge.
                    if (w_ss_fall) begin
                        r_end     <= 1'b1;
                        r_abort   <= (r_bit_cnt != '0);
                        r_active  <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end else if (w_sclk_rise) begin
                        r_mosi_sh <= {r_mosi_sh[DATA_SIZE-2:0], w_sync[L_MOSI]};
                        r_miso_sh <= {r_miso_sh[DATA_SIZE-2:0], w_sync[L_MISO]};
                        if (r_bit_cnt == CNT_MAX) begin
                            r_bit_cnt   <= '0;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= WAIT_IDLE;
            endcase

            // Completed words are published one cycle after the final sample lands.
            if (r_word_done) begin
                r_mosi_data <= r_mosi_sh;
                r_miso_data <= r_miso_sh;
                r_valid     <= 1'b1;
                if (r_valid && !data_ack) r_overrun <= 1'b1;
            end else if (r_valid && data_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign mosi_data    = r_mosi_data;
    assign miso_data    = r_miso_data;
    assign data_valid   = r_valid;
    assign frame_active = r_active;
    assign frame_start  = r_start;
    assign frame_end    = r_end;
    assign frame_abort  = r_abort;
    assign overrun      = r_overrun;

endmodule
